sico_chan_arbiter: RTL and testbench

- Shares the single outbound SiCo co-simulation channel between NUM_REQ packet-stream requesters, e.g. monitors and transactors that report to the host.
- Arbitrates round-robin at packet granularity and prefixes each packet with a header word carrying the source index.
- Clocked from the clock/reset pair produced by the SiCo control block.
- Higher-level control (tick/hold) can stall new arbitration through pause_i.

---
 rtl/sico_chan_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sico_chan_arbiter.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sico_chan_arbiter.sv
// -----------------------------------------------------------------------------
// sico_chan_arbiter
//
// Shares the single outbound SiCo co-simulation channel between NUM_REQ
// packet-stream requesters. Ownership is granted round-robin, one whole
// packet at a time. Every packet on the channel is prefixed with a header
// word that carries the owner's index in bits [7:0]. The remaining header
// bits are zero.
//
// Parameters
//   NUM_REQ      number of requester ports (2..16)
//   DATA_W       stream data width in bits (>= 8)
//
// Ports
//   clk_i        clock from the SiCo control block
//   rst_i        synchronous, active-high reset
//   req_valid_i  per-requester beat valid
//   req_data_i   per-requester data, requester k at [k*DATA_W +: DATA_W]
//   req_last_i   per-requester end-of-packet marker
//   req_ready_o  per-requester beat accept (only the owner, only in payload)
//   out_valid_o  channel beat valid
//   out_data_o   channel data (header word or owner's payload)
//   out_last_o   channel end-of-packet
//   out_ready_i  channel accept
//   pause_i      blocks the start of new packets (no effect mid-packet)
//   grant_o      one-hot current owner, zero when idle
//   busy_o       a packet (header or payload) is in progress
//   pkt_count_o  packets completed since reset, wraps at 2^32
// -----------------------------------------------------------------------------
module sico_chan_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]        req_last_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      out_valid_o,
    output logic [DATA_W-1:0]         out_data_o,
    output logic                      out_last_o,
    input  logic                      out_ready_i,
    input  logic                      pause_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic [31:0]               pkt_count_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_e;

    state_e             state_q,      state_d;
    logic [IDX_W-1:0]   owner_q,      owner_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [NUM_REQ-1:0] grant_q,      grant_d;
    logic [31:0]        pkt_count_q,  pkt_count_d;

    // Unpacked view of the flat data bus so the owner can be selected by index.
    logic [DATA_W-1:0]  req_data_arr [NUM_REQ];

    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    logic               own_valid;
    logic               own_last;
    logic [DATA_W-1:0]  own_data;
    logic               pkt_done;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    // Round-robin search: first valid requester starting just above the last
    // owner, wrapping modulo NUM_REQ. The last owner itself is checked last.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // otherwise paths that skip the assignment would infer latches.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = IDX_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!pick_found && req_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign own_valid = req_valid_i[owner_q];
    assign own_last  = req_last_i[owner_q];
    assign own_data  = req_data_arr[owner_q];

    // The closing beat of a packet: owner's last beat accepted by the channel.
    assign pkt_done  = (state_q == PAYLOAD) && own_valid && out_ready_i && own_last;

    // State register. Reset is synchronous and aborts any packet in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: registers are updated with non-blocking assignments so that
            // every flop samples the pre-edge values of the others.
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        pkt_count_d  = pkt_count_q;

        unique case (state_q)
            IDLE: begin
                if (!pause_i && pick_found) begin
                    state_d           = HEADER;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                end
            end
            HEADER: begin
                if (out_ready_i) begin
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                // A stalled owner keeps the channel locked; there is no timeout.
                if (pkt_done) begin
                    state_d      = IDLE;
                    pkt_count_d  = pkt_count_q + 32'd1;
                    last_grant_d = owner_q;
                    grant_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output logic. Payload is a zero-latency pass-through of the owner.
    always_comb begin
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_last_o  = 1'b0;
        req_ready_o = '0;

        unique case (state_q)
            IDLE: begin
            end
            HEADER: begin
                out_valid_o = 1'b1;
                out_data_o  = DATA_W'(owner_q);
            end
            PAYLOAD: begin
                out_valid_o = own_valid;
                out_data_o  = own_data;
                out_last_o  = own_last;
                req_ready_o = grant_q & {NUM_REQ{out_ready_i}};
            end
            default: begin
            end
        endcase
    end

    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);
    assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_sico_chan_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sico_chan_arbiter
//
// Requesters are modelled as packet queues that present their head beat and
// keep an offered beat until it is accepted. A transaction-level reference
// (owner index, header/payload phase, last owner, packet count) predicts every
// output each cycle. A scoreboard checks that each source's beats come out
// in order, exactly once, after a header naming that source. Directed scenarios
// are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sico_chan_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      out_valid_o;
    logic [DATA_W-1:0]         out_data_o;
    logic                      out_last_o;
    logic                      out_ready_i;
    logic                      pause_i;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      busy_o;
    logic [31:0]               pkt_count_o;

    always #5 clk_i = ~clk_i;

    sico_chan_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .pause_i     (pause_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .pkt_count_o (pkt_count_o)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t src_q [NUM_REQ][$];   // beats each requester still has to send
    beat_t exp_q [NUM_REQ][$];   // beats the channel still owes each source

    logic [NUM_REQ-1:0] offer;   // requester wants to present a new beat
    logic [NUM_REQ-1:0] stall;   // requester forced to drop valid
    logic [NUM_REQ-1:0] held;    // beat offered last cycle and not yet taken

    int n_checks;
    int n_fail;
    int cyc;

    // Reference model
    int          m_owner;        // -1 when no packet is in progress
    bit          m_hdr;          // header word still pending
    int          m_last;
    logic [31:0] m_count;

    // Scoreboard
    bit          sb_hdr;
    int          sb_src;
    int          done_cnt [NUM_REQ];
    int          hdr_log [$];
    logic [DATA_W-1:0] out_log [$];
    int          t_last;

    // Stability tracking while the channel back-pressures
    bit                prev_pending;
    logic [DATA_W-1:0] prev_data;

    // Last sampled DUT outputs
    logic [NUM_REQ-1:0] s_grant;
    logic [NUM_REQ-1:0] s_ready;
    logic               s_valid;
    logic               s_busy;
    logic [31:0]        s_count;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int i = 1; i <= NUM_REQ; i++) begin
            int c;
            c = (last + i) % NUM_REQ;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int k = 0; k < NUM_REQ; k++) n += src_q[k].size();
        return n;
    endfunction

    task automatic push_beat(input int k, input logic [DATA_W-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[k].push_back(b);
        exp_q[k].push_back(b);
    endtask

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            push_beat(k, DATA_W'($urandom), (i == len - 1));
        end
    endtask

    task automatic drive();
        beat_t b;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (src_q[k].size() > 0 && (offer[k] || held[k]) && !stall[k]) begin
                b = src_q[k][0];
                req_valid_i[k]                   = 1'b1;
                req_data_i[k*DATA_W +: DATA_W]   = b.data;
                req_last_i[k]                    = b.last;
            end else begin
                req_valid_i[k]                   = 1'b0;
                req_data_i[k*DATA_W +: DATA_W]   = '0;
                req_last_i[k]                    = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check against the model mid-cycle, advance.
    task automatic cycle();
        logic [NUM_REQ-1:0] eg;
        logic [NUM_REQ-1:0] er;
        beat_t              e;
        int                 p;

        drive();
        #4;

        s_grant = grant_o;
        s_ready = req_ready_o;
        s_valid = out_valid_o;
        s_busy  = busy_o;
        s_count = pkt_count_o;

        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        check("grant", grant_o, eg);
        check("busy", busy_o, (m_owner >= 0));
        check("pkt_count", pkt_count_o, m_count);

        if (m_owner < 0) begin
            check("idle_valid", out_valid_o, 1'b0);
            check("idle_ready", req_ready_o, '0);
        end else if (m_hdr) begin
            check("hdr_valid", out_valid_o, 1'b1);
            check("hdr_data", out_data_o, DATA_W'(m_owner));
            check("hdr_last", out_last_o, 1'b0);
            check("hdr_ready", req_ready_o, '0);
        end else begin
            er = '0;
            er[m_owner] = out_ready_i;
            check("pay_valid", out_valid_o, req_valid_i[m_owner]);
            check("pay_data", out_data_o, req_data_i[m_owner*DATA_W +: DATA_W]);
            check("pay_last", out_last_o, req_last_i[m_owner]);
            check("pay_ready", req_ready_o, er);
        end

        if (prev_pending && stall == '0) begin
            check("hold_valid", out_valid_o, 1'b1);
            check("hold_data", out_data_o, prev_data);
        end
        prev_pending = out_valid_o && !out_ready_i && !rst_i;
        prev_data    = out_data_o;

        // Scoreboard on channel transfers
        if (out_valid_o && out_ready_i && !rst_i) begin
            out_log.push_back(out_data_o);
            if (sb_hdr) begin
                hdr_log.push_back(int'(out_data_o[7:0]));
                sb_src = (int'(out_data_o[7:0]) < NUM_REQ) ? int'(out_data_o[7:0]) : 0;
                sb_hdr = 1'b0;
            end else begin
                check("sb_beat_expected", exp_q[sb_src].size() > 0, 1'b1);
                if (exp_q[sb_src].size() > 0) begin
                    e = exp_q[sb_src].pop_front();
                    check("sb_data", out_data_o, e.data);
                    check("sb_last", out_last_o, e.last);
                    if (e.last) begin
                        done_cnt[sb_src]++;
                        sb_hdr = 1'b1;
                        t_last = cyc;
                    end
                end
            end
        end

        // Requesters retire accepted beats and hold offered ones
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid_i[k] && req_ready_o[k] && !rst_i) void'(src_q[k].pop_front());
            held[k] = req_valid_i[k] && !req_ready_o[k];
        end

        // Reference model advances to the state after this edge
        if (rst_i) begin
            m_owner = -1;
            m_hdr   = 1'b0;
            m_last  = NUM_REQ - 1;
            m_count = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                src_q[k].delete();
                exp_q[k].delete();
            end
            sb_hdr       = 1'b1;
            held         = '0;
            prev_pending = 1'b0;
        end else if (m_owner < 0) begin
            if (!pause_i) begin
                p = rr_pick(req_valid_i, m_last);
                if (p >= 0) begin
                    m_owner = p;
                    m_hdr   = 1'b1;
                end
            end
        end else if (m_hdr) begin
            if (out_ready_i) m_hdr = 1'b0;
        end else if (req_valid_i[m_owner] && out_ready_i && req_last_i[m_owner]) begin
            m_count = m_count + 32'd1;
            m_last  = m_owner;
            m_owner = -1;
        end

        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((pending() > 0 || s_busy) && n < budget);
        check("drain_timeout", pending() + int'(s_busy), 0);
    endtask

    task automatic clear_logs();
        hdr_log.delete();
        out_log.delete();
        for (int k = 0; k < NUM_REQ; k++) done_cnt[k] = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] t1_exp [4];
        int t0;
        int n;

        n_checks = 0; n_fail = 0; cyc = 0;
        rst_i = 1'b1; out_ready_i = 1'b1; pause_i = 1'b0;
        req_valid_i = '0; req_data_i = '0; req_last_i = '0;
        offer = '0; stall = '0; held = '0;
        m_owner = -1; m_hdr = 1'b0; m_last = NUM_REQ - 1; m_count = '0;
        sb_hdr = 1'b1; sb_src = 0; t_last = 0;
        prev_pending = 1'b0; prev_data = '0;
        s_busy = 1'b0; s_grant = '0; s_ready = '0; s_valid = 1'b0; s_count = '0;
        clear_logs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Reset state
        cycle();
        check("reset_count", s_count, 32'd0);
        check("reset_grant", s_grant, '0);

        // Single 3-beat packet from requester 2
        do_reset();
        clear_logs();
        t1_exp[0] = 32'h0000_0002;
        t1_exp[1] = 32'hA5A5_0001;
        t1_exp[2] = 32'hB6B6_0002;
        t1_exp[3] = 32'hC7C7_0003;
        push_beat(2, t1_exp[1], 1'b0);
        push_beat(2, t1_exp[2], 1'b0);
        push_beat(2, t1_exp[3], 1'b1);
        offer = 4'b0100;
        t0 = cyc;
        run_until_idle(50);
        check("t1_len", out_log.size(), 4);
        if (out_log.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t1_seq", out_log[i], t1_exp[i]);
        end
        check("t1_count", s_count, 32'd1);
        check("t1_latency", t_last + 1 - t0, 5);
        offer = '0;

        // Round-robin among four always-offering requesters
        do_reset();
        clear_logs();
        for (int k = 0; k < NUM_REQ; k++) begin
            push_pkt(k, 1);
            push_pkt(k, 1);
        end
        offer = '1;
        run_until_idle(100);
        check("rr_headers", hdr_log.size(), 8);
        for (int i = 0; i < hdr_log.size() && i < 8; i++) check("rr_order", hdr_log[i], i % NUM_REQ);
        check("rr_count", s_count, 32'd8);
        for (int k = 0; k < NUM_REQ; k++) check("rr_per_src", done_cnt[k], 2);
        offer = '0;

        // Back-pressure with out_ready_i toggling during a 4-beat packet
        do_reset();
        clear_logs();
        push_pkt(1, 4);
        offer = 4'b0010;
        n = 0;
        do begin
            out_ready_i = (n % 2 == 0);
            cycle();
            n++;
        end while ((pending() > 0 || s_busy) && n < 60);
        out_ready_i = 1'b1;
        check("bp_drained", exp_q[1].size(), 0);
        check("bp_beats", out_log.size(), 5);
        check("bp_count", s_count, 32'd1);
        offer = '0;

        // Pause raised mid-packet, pending requester 3 held off
        do_reset();
        clear_logs();
        push_pkt(0, 3);
        push_pkt(3, 1);
        offer = 4'b1001;
        cycle();
        cycle();
        pause_i = 1'b1;
        n = 0;
        while (exp_q[0].size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        check("pause_pkt_done", exp_q[0].size(), 0);
        repeat (4) begin
            cycle();
            check("pause_no_grant", s_grant, '0);
            check("pause_idle", s_busy, 1'b0);
        end
        pause_i = 1'b0;
        cycle();
        cycle();
        check("pause_release_grant", s_grant, 4'b1000);
        run_until_idle(20);

        // Reset in the middle of a payload from requester 1
        clear_logs();
        push_pkt(1, 4);
        offer = 4'b0010;
        n = 0;
        while (exp_q[1].size() > 2 && n < 20) begin
            cycle();
            n++;
        end
        check("rst_mid_beats", exp_q[1].size(), 2);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        offer = '0;
        cycle();
        check("rst_out_valid", s_valid, 1'b0);
        check("rst_grant", s_grant, '0);
        check("rst_busy", s_busy, 1'b0);
        check("rst_ready", s_ready, '0);
        check("rst_count", s_count, 32'd0);
        clear_logs();
        push_pkt(1, 2);
        push_pkt(3, 1);
        offer = 4'b1010;
        run_until_idle(30);
        check("rst_first_grant", (hdr_log.size() > 0) ? hdr_log[0] : -1, 1);
        offer = '0;

        // Owner drops valid for 5 cycles while requester 2 waits
        do_reset();
        clear_logs();
        push_pkt(0, 4);
        push_pkt(2, 1);
        offer = 4'b0101;
        cycle();
        cycle();
        cycle();
        stall = 4'b0001;
        repeat (5) begin
            cycle();
            check("stall_valid", s_valid, 1'b0);
            check("stall_grant", s_grant, 4'b0001);
            check("stall_ready2", s_ready[2], 1'b0);
        end
        stall = '0;
        run_until_idle(30);
        check("stall_src0_done", done_cnt[0], 1);
        check("stall_src2_done", done_cnt[2], 1);
        offer = '0;

        // Randomized traffic, back-pressure, pause and occasional reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (src_q[k].size() < 3 && ($urandom % 8) == 0) push_pkt(k, 1 + int'($urandom % 5));
            end
            offer       = NUM_REQ'($urandom);
            out_ready_i = (($urandom % 4) != 0);
            pause_i     = (($urandom % 6) == 0);
            rst_i       = (($urandom % 500) == 0);
            cycle();
            rst_i = 1'b0;
        end
        pause_i     = 1'b0;
        out_ready_i = 1'b1;
        offer       = '1;
        run_until_idle(2000);
        for (int k = 0; k < NUM_REQ; k++) check("rand_drained", exp_q[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
